// File: rtl/instr_sequencer.sv
// instr_sequencer: multi-cycle fetch/decode/execute controller for the 16-bit
// accumulator core. Fetches from program memory into IR, decodes the opcode and
// sequences the ALU, register file and data-memory request/ack handshake.
//
// Ports:
//   clk, rst_n            core clock, asynchronous active-low reset
//   run                   1 = keep executing, 0 = stop at next instruction boundary
//   instruction_address   program-memory address (PC captured on FETCH entry)
//   instruction           program-memory read data (combinational)
//   alu_en, alu_op        ALU strobe and operation (IR[14:12])
//   reg_sel               register-file operand/destination (IR[11:10])
//   rf_we, rf_wsel        register-file write strobe, source (0 ALU, 1 memory)
//   mem_addr              data-memory address (IR[9:0])
//   mem_req, mem_we       data-memory request, 1 = store
//   mem_ack               data-memory acknowledge, only observed in MEM
//   busy                  high in every state except IDLE
//   retire                pulse on the last cycle of each completed instruction
//   illegal_op            pulse in DECODE for an undefined opcode
//   mem_timeout           pulse when a MEM wait is abandoned
//
// MEM_TIMEOUT is the maximum number of MEM cycles per access; legal range 1..255.

module instr_sequencer #(
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        run,
    output logic [4:0]  instruction_address,
    input  logic [15:0] instruction,
    output logic        alu_en,
    output logic [2:0]  alu_op,
    output logic [1:0]  reg_sel,
    output logic        rf_we,
    output logic        rf_wsel,
    output logic [9:0]  mem_addr,
    output logic        mem_req,
    output logic        mem_we,
    input  logic        mem_ack,
    output logic        busy,
    output logic        retire,
    output logic        illegal_op,
    output logic        mem_timeout
);

    localparam int unsigned PC_W  = 5;
    localparam int unsigned IR_W  = 16;
    localparam int unsigned CNT_W = 8;

    // Wait-counter value seen in the last permitted MEM cycle.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

    localparam logic [3:0] OP_LOAD  = 4'h6;
    localparam logic [3:0] OP_STORE = 4'h7;
    localparam logic [3:0] OP_NOP   = 4'hF;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        MEM    = 3'd4,
        WB     = 3'd5
    } state_t;

    function automatic logic op_is_alu(input logic [3:0] op);
        return (op <= 4'h5);
    endfunction

    function automatic logic op_is_mem(input logic [3:0] op);
        return (op == OP_LOAD) || (op == OP_STORE);
    endfunction

    function automatic logic op_is_illegal(input logic [3:0] op);
        return op[3] && (op != OP_NOP);
    endfunction

    state_t           state_q, state_d;
    state_t           boundary_state;
    logic [PC_W-1:0]  pc_q, pc_d;
    logic [IR_W-1:0]  ir_q, ir_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       op_q, op_d;

    logic             mem_retire_c;
    logic             mem_to_c;
    logic             retire_q;

    logic [PC_W-1:0]  iaddr_d;
    logic             alu_en_d, rf_we_d, rf_wsel_d, mem_req_d, mem_we_d;
    logic             busy_d, retire_d, illegal_d;

    assign op_q = ir_q[15:12];
    assign op_d = ir_d[15:12];

    // Where to go at an instruction boundary; run is only looked at here.
    assign boundary_state = run ? FETCH : IDLE;

    // Next-state logic.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        ir_d         = ir_q;
        cnt_d        = cnt_q;
        mem_retire_c = 1'b0;
        mem_to_c     = 1'b0;

        case (state_q)
            IDLE: begin
                if (run) begin
                    state_d = FETCH;
                end
            end
            FETCH: begin
                ir_d    = instruction;
                pc_d    = pc_q + PC_W'(1);
                state_d = DECODE;
            end
            DECODE: begin
                if (op_is_alu(op_q)) begin
                    state_d = EXEC;
                end else if (op_is_mem(op_q)) begin
                    state_d = MEM;
                    cnt_d   = '0;
                end else begin
                    state_d = boundary_state;
                end
            end
            EXEC: begin
                state_d = boundary_state;
            end
            MEM: begin
                // Ack takes priority over an expiring wait.
                if (mem_ack) begin
                    if (op_q == OP_LOAD) begin
                        state_d = WB;
                    end else begin
                        state_d      = boundary_state;
                        mem_retire_c = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_LAST) begin
                        state_d      = boundary_state;
                        mem_retire_c = 1'b1;
                        mem_to_c     = 1'b1;
                    end
                end
            end
            WB: begin
                state_d = boundary_state;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output decode from the upcoming state and IR, so the strobes are
    // registered yet line up with the state they belong to.
    always_comb begin
        alu_en_d  = 1'b0;
        rf_we_d   = 1'b0;
        rf_wsel_d = 1'b0;
        mem_req_d = 1'b0;
        mem_we_d  = 1'b0;
        retire_d  = 1'b0;
        illegal_d = 1'b0;
        busy_d    = (state_d != IDLE);
        iaddr_d   = instruction_address;

        case (state_d)
            FETCH: begin
                iaddr_d = pc_d;
            end
            DECODE: begin
                retire_d  = !op_is_alu(op_d) && !op_is_mem(op_d);
                illegal_d = op_is_illegal(op_d);
            end
            EXEC: begin
                alu_en_d = 1'b1;
                rf_we_d  = 1'b1;
                retire_d = 1'b1;
            end
            MEM: begin
                mem_req_d = 1'b1;
                mem_we_d  = (op_d == OP_STORE);
            end
            WB: begin
                rf_we_d   = 1'b1;
                rf_wsel_d = 1'b1;
                retire_d  = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // State, datapath registers and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q             <= IDLE;
            pc_q                <= '0;
            ir_q                <= '0;
            cnt_q               <= '0;
            instruction_address <= '0;
            alu_en              <= 1'b0;
            rf_we               <= 1'b0;
            rf_wsel             <= 1'b0;
            mem_req             <= 1'b0;
            mem_we              <= 1'b0;
            busy                <= 1'b0;
            retire_q            <= 1'b0;
            illegal_op          <= 1'b0;
        end else begin
            state_q             <= state_d;
            pc_q                <= pc_d;
            ir_q                <= ir_d;
            cnt_q               <= cnt_d;
            instruction_address <= iaddr_d;
            alu_en              <= alu_en_d;
            rf_we               <= rf_we_d;
            rf_wsel             <= rf_wsel_d;
            mem_req             <= mem_req_d;
            mem_we              <= mem_we_d;
            busy                <= busy_d;
            retire_q            <= retire_d;
            illegal_op          <= illegal_d;
        end
    end

    // IR fields drive the datapath continuously.
    assign alu_op   = ir_q[14:12];
    assign reg_sel  = ir_q[11:10];
    assign mem_addr = ir_q[9:0];

    // A STORE or timed-out access ends in the same MEM cycle that sees the
    // ack/expiry, so that part of retire follows mem_ack directly.
    assign retire      = retire_q | mem_retire_c;
    assign mem_timeout = mem_to_c;

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: expected per-instruction records are
// queued ahead of execution and compared each time retire is observed.

module tb_instr_sequencer;

    localparam int unsigned TO = 4;

    logic        clk;
    logic        rst_n;
    logic        run;
    logic [4:0]  instruction_address;
    logic [15:0] instruction;
    logic        alu_en;
    logic [2:0]  alu_op;
    logic [1:0]  reg_sel;
    logic        rf_we;
    logic        rf_wsel;
    logic [9:0]  mem_addr;
    logic        mem_req;
    logic        mem_we;
    logic        mem_ack;
    logic        busy;
    logic        retire;
    logic        illegal_op;
    logic        mem_timeout;

    instr_sequencer #(.MEM_TIMEOUT(TO)) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .run                 (run),
        .instruction_address (instruction_address),
        .instruction         (instruction),
        .alu_en              (alu_en),
        .alu_op              (alu_op),
        .reg_sel             (reg_sel),
        .rf_we               (rf_we),
        .rf_wsel             (rf_wsel),
        .mem_addr            (mem_addr),
        .mem_req             (mem_req),
        .mem_we              (mem_we),
        .mem_ack             (mem_ack),
        .busy                (busy),
        .retire              (retire),
        .illegal_op          (illegal_op),
        .mem_timeout         (mem_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Program memory.
    logic [15:0] pmem [32];
    assign instruction = pmem[instruction_address];

    // Memory responder: ack tied high, or ack in the Nth consecutive request
    // cycle (ack_delay = 0 means never).
    logic ack_tied;
    int   ack_delay;
    int   req_run;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)       req_run <= 0;
        else if (mem_req) req_run <= req_run + 1;
        else              req_run <= 0;
    end
    assign mem_ack = ack_tied || (mem_req && ack_delay != 0 && req_run == ack_delay - 1);

    typedef struct packed {
        logic [4:0] addr;
        logic [3:0] cycles, n_req, n_we, n_alu, n_rfwe, n_wsel, n_to, n_ill;
        logic [2:0] alu_op;
        logic [1:0] reg_sel;
        logic [9:0] mem_addr;
    } rec_t;

    rec_t sb[$];
    rec_t acc;
    int   n_checks = 0;
    int   n_errors = 0;

    function automatic rec_t mk(input logic [4:0] a, input int cyc, input int req,
                                input int we, input int alu, input int rfwe,
                                input int wsel, input int to, input int ill);
        rec_t r;
        logic [15:0] w;
        w          = pmem[a];
        r.addr     = a;
        r.cycles   = 4'(cyc);
        r.n_req    = 4'(req);
        r.n_we     = 4'(we);
        r.n_alu    = 4'(alu);
        r.n_rfwe   = 4'(rfwe);
        r.n_wsel   = 4'(wsel);
        r.n_to     = 4'(to);
        r.n_ill    = 4'(ill);
        r.alu_op   = w[14:12];
        r.reg_sel  = w[11:10];
        r.mem_addr = w[9:0];
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock: sample at the falling edge, accumulate strobes of the
    // instruction in flight and score it when it retires.
    task automatic tick();
        rec_t exp;
        @(negedge clk);
        if (!rst_n || !busy) begin
            acc = '0;
        end else begin
            acc.cycles = acc.cycles + 4'd1;
            if (mem_req)          acc.n_req  = acc.n_req  + 4'd1;
            if (mem_req && mem_we) acc.n_we  = acc.n_we   + 4'd1;
            if (alu_en)           acc.n_alu  = acc.n_alu  + 4'd1;
            if (rf_we)            acc.n_rfwe = acc.n_rfwe + 4'd1;
            if (rf_we && rf_wsel) acc.n_wsel = acc.n_wsel + 4'd1;
            if (mem_timeout)      acc.n_to   = acc.n_to   + 4'd1;
            if (illegal_op)       acc.n_ill  = acc.n_ill  + 4'd1;
            if (retire) begin
                acc.addr     = instruction_address;
                acc.alu_op   = alu_op;
                acc.reg_sel  = reg_sel;
                acc.mem_addr = mem_addr;
                n_checks++;
                if (sb.size() == 0) begin
                    n_errors++;
                    $error("FAIL retire_unexpected: observed %h expected none", acc);
                end else begin
                    exp = sb.pop_front();
                    assert (acc === exp) else begin
                        n_errors++;
                        $error("FAIL retire@%0d: observed %h expected %h", exp.addr, acc, exp);
                    end
                end
                acc = '0;
            end
        end
    endtask

    task automatic wait_retire(input string tag);
        bit seen = 1'b0;
        for (int t = 0; t < 40 && !seen; t++) begin
            tick();
            seen = rst_n && busy && retire;
        end
        n_checks++;
        assert (seen) else begin
            n_errors++;
            $error("FAIL %s: observed no retire expected retire within 40 cycles", tag);
        end
    endtask

    task automatic wait_req(input string tag);
        bit seen = 1'b0;
        for (int t = 0; t < 40 && !seen; t++) begin
            tick();
            seen = mem_req;
        end
        n_checks++;
        assert (seen) else begin
            n_errors++;
            $error("FAIL %s: observed no mem_req expected mem_req within 40 cycles", tag);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        run       = 1'b0;
        ack_tied  = 1'b1;
        ack_delay = 0;
        acc       = '0;

        pmem[0] = 16'hF000;   // NOP
        pmem[1] = 16'h0000;   // ADD r0
        pmem[2] = 16'h6000;   // LOAD r0 @0
        pmem[3] = 16'h7405;   // STORE r1 @5
        pmem[4] = 16'h683A;   // LOAD r2 @0x3A
        pmem[5] = 16'h1C07;   // SUB r3
        pmem[6] = 16'h2400;   // AND r1
        pmem[7] = 16'h3800;   // OR r2
        pmem[8] = 16'h4000;   // XOR r0
        pmem[9] = 16'h5C00;   // NOT r3
        for (int a = 10; a < 31; a++) pmem[a] = 16'hF000;
        pmem[31] = 16'hA123;  // illegal opcode 1010

        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        // Reset / idle state.
        check("rst_iaddr",   32'(instruction_address), 32'd0);
        check("rst_alu_en",  32'(alu_en), 32'd0);
        check("rst_alu_op",  32'(alu_op), 32'd0);
        check("rst_reg_sel", 32'(reg_sel), 32'd0);
        check("rst_rf_we",   32'(rf_we), 32'd0);
        check("rst_rf_wsel", 32'(rf_wsel), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_mem_we",  32'(mem_we), 32'd0);
        check("rst_busy",    32'(busy), 32'd0);
        check("rst_retire",  32'(retire), 32'd0);
        check("rst_illegal", 32'(illegal_op), 32'd0);
        check("rst_timeout", 32'(mem_timeout), 32'd0);

        // First pass through program memory, then wrap to 0..2.
        sb.push_back(mk(5'd0, 2, 0, 0, 0, 0, 0, 0, 0));
        sb.push_back(mk(5'd1, 3, 0, 0, 1, 1, 0, 0, 0));
        sb.push_back(mk(5'd2, 4, 1, 0, 0, 1, 1, 0, 0));
        sb.push_back(mk(5'd3, 6, 4, 4, 0, 0, 0, 0, 0));
        sb.push_back(mk(5'd4, 2 + TO, TO, 0, 0, 0, 0, 1, 0));
        for (int a = 5; a < 10; a++)  sb.push_back(mk(5'(a), 3, 0, 0, 1, 1, 0, 0, 0));
        for (int a = 10; a < 31; a++) sb.push_back(mk(5'(a), 2, 0, 0, 0, 0, 0, 0, 0));
        sb.push_back(mk(5'd31, 2, 0, 0, 0, 0, 0, 0, 1));
        sb.push_back(mk(5'd0, 2, 0, 0, 0, 0, 0, 0, 0));
        sb.push_back(mk(5'd1, 3, 0, 0, 1, 1, 0, 0, 0));
        sb.push_back(mk(5'd2, 6, 3, 0, 0, 1, 1, 0, 0));

        run = 1'b1;
        tick();
        check("run_busy",  32'(busy), 32'd1);
        check("run_iaddr", 32'(instruction_address), 32'd0);

        wait_retire("nop0");
        wait_retire("add1");
        wait_retire("load2");
        @(posedge clk); #1;
        ack_tied  = 1'b0;
        ack_delay = 4;            // ack lands in the final permitted MEM cycle
        wait_retire("store3");
        @(posedge clk); #1;
        ack_delay = 0;            // never ack: timeout
        wait_retire("load4_timeout");
        for (int a = 5; a < 32; a++) wait_retire($sformatf("instr%0d", a));
        wait_retire("nop0_wrap");
        wait_retire("add1_wrap");
        @(posedge clk); #1;
        ack_delay = 3;

        // Drop run while the LOAD is waiting; it must still write back.
        wait_req("load2_req");
        run = 1'b0;
        wait_retire("load2_wb");
        tick();
        tick();
        check("stop_busy",  32'(busy), 32'd0);
        check("stop_iaddr", 32'(instruction_address), 32'd2);
        check("stop_mem_req", 32'(mem_req), 32'd0);

        // Reset in the middle of a STORE wait.
        ack_delay = 0;
        run       = 1'b1;
        wait_req("store3_req");
        check("mid_mem_we", 32'(mem_we), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst_mid_mem_req", 32'(mem_req), 32'd0);
        check("rst_mid_mem_we",  32'(mem_we), 32'd0);
        check("rst_mid_busy",    32'(busy), 32'd0);
        check("rst_mid_iaddr",   32'(instruction_address), 32'd0);
        check("rst_mid_mem_addr", 32'(mem_addr), 32'd0);
        tick();
        tick();
        ack_tied = 1'b1;
        rst_n    = 1'b1;

        // Execution restarts from PC 0.
        sb.push_back(mk(5'd0, 2, 0, 0, 0, 0, 0, 0, 0));
        sb.push_back(mk(5'd1, 3, 0, 0, 1, 1, 0, 0, 0));
        wait_retire("nop0_after_rst");
        wait_retire("add1_after_rst");
        run = 1'b0;
        repeat (3) tick();
        check("end_busy", 32'(busy), 32'd0);
        check("end_sb_empty", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
